// File: rtl/pe_mac_accumulate.sv
// pe_mac_accumulate
// Compute stage of one PE in the linear matrix-multiply array. The block
// takes paired A/B operands from the load stage and accumulates PE_NUM row
// partial sums over K_NUM rank-1 steps per tile. Finished sums are swapped
// into a drain buffer and streamed out over valid/ready, so the next tile
// can accumulate while the previous one drains.
//
// Pipeline:
//   edge T   : beat captured into the operand register (stage 0)
//   edge T+1 : signed product registered (stage 1)
//   edge T+2 : accumulator update; on the tile's last beat, swap into drain
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   data_A_in/B_in    signed operands, D_WIDTH each
//   valid_AB_in       operand pair valid
//   in_ready          beat can be accepted this cycle
//   c_data/c_index    finished sum and its row index
//   c_last            final row of the tile
//   c_valid/c_ready   result handshake
//   overflow_err      sticky: a beat was offered while in_ready was low

// One row of the PE. It holds the running sum and the drain slot for that row.
// The data registers are not reset: their contents are never visible while
// the control state says they are empty.
module pe_mac_row #(
    parameter int ACC_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 upd,
    input  logic                 first,
    input  logic [ACC_WIDTH-1:0] prod,
    input  logic                 swap,
    output logic [ACC_WIDTH-1:0] acc,
    output logic [ACC_WIDTH-1:0] drain
);
    logic [ACC_WIDTH-1:0] next_sum;

    // The k=0 beat overwrites the row, so no clear is needed between tiles.
    assign next_sum = first ? prod : acc + prod;

    always_ff @(posedge clk) begin
        if (upd)
            acc <= next_sum;
        // The row updated in the swap cycle forwards its fresh sum. Every
        // other row copies its settled accumulator.
        if (swap)
            drain <= upd ? next_sum : acc;
    end
endmodule

module pe_mac_accumulate #(
    parameter int D_WIDTH      = 64,
    parameter int ACC_WIDTH    = 64,
    parameter int PE_NUM_WIDTH = 1,
    parameter int PE_NUM       = 2,
    parameter int K_NUM        = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [D_WIDTH-1:0]      data_A_in,
    input  logic [D_WIDTH-1:0]      data_B_in,
    input  logic                    valid_AB_in,
    output logic                    in_ready,
    output logic [ACC_WIDTH-1:0]    c_data,
    output logic [PE_NUM_WIDTH-1:0] c_index,
    output logic                    c_last,
    output logic                    c_valid,
    input  logic                    c_ready,
    output logic                    overflow_err
);
    localparam int TOTAL  = PE_NUM * K_NUM;
    localparam int CNT_W  = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int STAGES = 1;
    localparam logic [CNT_W-1:0]        LAST_CNT = CNT_W'(TOTAL - 1);
    localparam logic [PE_NUM_WIDTH-1:0] LAST_ROW = PE_NUM_WIDTH'(PE_NUM - 1);

    typedef struct packed {
        logic [D_WIDTH-1:0]      a;
        logic [D_WIDTH-1:0]      b;
        logic [PE_NUM_WIDTH-1:0] idx;
        logic                    first;
        logic                    last;
    } op_t;

    typedef struct packed {
        logic [ACC_WIDTH-1:0]    prod;
        logic [PE_NUM_WIDTH-1:0] idx;
        logic                    first;
        logic                    last;
    } prod_t;

    logic [CNT_W-1:0]        beat_cnt;
    logic [PE_NUM_WIDTH-1:0] rd_idx;
    logic                    drain_full;
    logic [STAGES:0]         vld_pipe;   // [0]: operand reg, [1]: product reg

    op_t   s0_q, s0_d;
    prod_t s1_q, s1_d;

    logic accept, is_last, is_first;
    logic swap_inflight, hs_last, drain_busy, swap;
    logic signed [ACC_WIDTH-1:0] a_sx, b_sx;

    logic [PE_NUM-1:0]                upd;
    logic [PE_NUM-1:0][ACC_WIDTH-1:0] acc_q;
    logic [PE_NUM-1:0][ACC_WIDTH-1:0] drain_q;

    // Beat position: row is the low bits, step k the high bits.
    assign is_last  = (beat_cnt == LAST_CNT);
    assign is_first = ((beat_cnt >> PE_NUM_WIDTH) == '0);

    // A final beat may only enter when its swap can land in an empty drain.
    // A drain that completes this cycle counts as empty. A swap still in
    // stage 0/1 blocks it, so at most one swap is ever pending.
    assign swap_inflight = (vld_pipe[0] && s0_q.last) || (vld_pipe[1] && s1_q.last);
    assign hs_last       = c_valid && c_ready && c_last;
    assign drain_busy    = drain_full && !hs_last;
    assign in_ready      = !(is_last && (drain_busy || swap_inflight));
    assign accept        = valid_AB_in && in_ready;

    assign swap = vld_pipe[1] && s1_q.last;

    // Stage 0 operand capture
    always_comb begin
        s0_d       = s0_q;
        s0_d.a     = data_A_in;
        s0_d.b     = data_B_in;
        s0_d.idx   = beat_cnt[PE_NUM_WIDTH-1:0];
        s0_d.first = is_first;
        s0_d.last  = is_last;
    end

    // Stage 1 product. Both operands are sign-extended to ACC_WIDTH first.
    // The low ACC_WIDTH bits of that product equal the full product,
    // sign-extended or truncated to ACC_WIDTH.
    always_comb begin
        a_sx       = ACC_WIDTH'($signed(s0_q.a));
        b_sx       = ACC_WIDTH'($signed(s0_q.b));
        s1_d.prod  = a_sx * b_sx;
        s1_d.idx   = s0_q.idx;
        s1_d.first = s0_q.first;
        s1_d.last  = s0_q.last;
    end

    always_ff @(posedge clk) begin
        if (accept)
            s0_q <= s0_d;
        if (vld_pipe[0])
            s1_q <= s1_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe     <= '0;
            beat_cnt     <= '0;
            rd_idx       <= '0;
            drain_full   <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], accept};

            if (accept)
                beat_cnt <= is_last ? '0 : beat_cnt + CNT_W'(1);

            if (c_valid && c_ready)
                rd_idx <= c_last ? '0 : rd_idx + PE_NUM_WIDTH'(1);

            if (swap)
                drain_full <= 1'b1;
            else if (hs_last)
                drain_full <= 1'b0;

            // A rejected beat changes nothing except this flag.
            if (valid_AB_in && !in_ready)
                overflow_err <= 1'b1;
        end
    end

    // Stage 2 row lanes
    always_comb begin
        for (int j = 0; j < PE_NUM; j++)
            upd[j] = vld_pipe[1] && (s1_q.idx == PE_NUM_WIDTH'(j));
    end

    for (genvar j = 0; j < PE_NUM; j++) begin : g_row
        pe_mac_row #(
            .ACC_WIDTH (ACC_WIDTH)
        ) u_row (
            .clk   (clk),
            .upd   (upd[j]),
            .first (s1_q.first),
            .prod  (s1_q.prod),
            .swap  (swap),
            .acc   (acc_q[j]),
            .drain (drain_q[j])
        );
    end

    // Drain output. The data output is forced to zero when empty, so stale
    // buffer contents never appear on the bus.
    assign c_valid = drain_full;
    assign c_index = rd_idx;
    assign c_last  = drain_full && (rd_idx == LAST_ROW);
    assign c_data  = drain_full ? drain_q[rd_idx] : '0;
endmodule

// File: tb/tb_pe_mac_accumulate.sv
// Directed bench for pe_mac_accumulate. The main instance is PE_NUM=2,
// K_NUM=3, 64-bit. A second instance is 8-bit with K_NUM=2 and exercises
// modular wrap of the accumulator.
module tb_pe_mac_accumulate;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] a, b, c_data;
    logic        v, in_ready, c_index, c_last, c_valid, cr, ovf;

    logic [7:0]  wa, wb, w_data;
    logic        wv, w_ready, w_index, w_last, w_valid, w_ovf;
    logic        w_cr;

    int total = 0;
    int bad = 0;
    int ir_low;
    logic ok;

    longint ta [5][6];
    longint tbv[5][6];
    longint e0 [5];
    longint e1 [5];

    logic [63:0] qd[$];
    logic        qi[$];
    logic        ql[$];

    pe_mac_accumulate #(
        .D_WIDTH(64), .ACC_WIDTH(64), .PE_NUM_WIDTH(1), .PE_NUM(2), .K_NUM(3)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .data_A_in(a), .data_B_in(b), .valid_AB_in(v), .in_ready(in_ready),
        .c_data(c_data), .c_index(c_index), .c_last(c_last),
        .c_valid(c_valid), .c_ready(cr), .overflow_err(ovf)
    );

    pe_mac_accumulate #(
        .D_WIDTH(8), .ACC_WIDTH(8), .PE_NUM_WIDTH(1), .PE_NUM(2), .K_NUM(2)
    ) dut_w (
        .clk(clk), .rst_n(rst_n),
        .data_A_in(wa), .data_B_in(wb), .valid_AB_in(wv), .in_ready(w_ready),
        .c_data(w_data), .c_index(w_index), .c_last(w_last),
        .c_valid(w_valid), .c_ready(w_cr), .overflow_err(w_ovf)
    );

    // Record every accepted result just before the edge that takes it.
    always begin
        @(negedge clk);
        #4;
        if (c_valid && cr) begin
            qd.push_back(c_data);
            qi.push_back(c_index);
            ql.push_back(c_last);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic qclear();
        qd.delete();
        qi.delete();
        ql.delete();
    endtask

    // Present n beats of tile t starting at beat s, one per cycle.
    task automatic send(input int t, input int s, input int n);
        for (int j = s; j < s + n; j++) begin
            a = 64'(ta[t][j]);
            b = 64'(tbv[t][j]);
            v = 1'b1;
            #1;
            if (!in_ready) ir_low++;
            @(negedge clk);
        end
        v = 1'b0;
    endtask

    task automatic check_q(input string tag, input int t0, input int nt);
        int t;
        logic [63:0] e;
        chk({tag, "_cnt"}, 64'(qd.size()), 64'(2 * nt));
        for (int i = 0; i < 2 * nt; i++) begin
            t = t0 + i / 2;
            e = (i % 2 == 0) ? 64'(e0[t]) : 64'(e1[t]);
            if (i < qd.size()) begin
                chk({tag, "_data"}, qd[i], e);
                chk({tag, "_idx"}, 64'(qi[i]), 64'(i % 2));
                chk({tag, "_last"}, 64'(ql[i]), 64'(i % 2));
            end
        end
    endtask

    initial begin
        // tile 0: single-tile case; rows: 2+30-10, 12+56+4
        ta[0] = '{1, 3, 5, 7, -1, 2};   tbv[0] = '{2, 4, 6, 8, 10, 2};
        e0[0] = 22;  e1[0] = 72;
        // tile 1: 1+9+25, 4+16+36
        ta[1] = '{1, 2, 3, 4, 5, 6};    tbv[1] = '{1, 2, 3, 4, 5, 6};
        e0[1] = 35;  e1[1] = 56;
        // tile 2: -6+100+9, -20+0+1
        ta[2] = '{-2, 4, 10, 0, -3, 1}; tbv[2] = '{3, -5, 10, 7, -3, 1};
        e0[2] = 103; e1[2] = -19;
        // tile 3: 6+16+1, 1+10+9
        ta[3] = '{2, 1, 4, 2, -1, 3};   tbv[3] = '{3, 1, 4, 5, -1, 3};
        e0[3] = 23;  e1[3] = 20;
        // tile 4: 49+0-8, -2+9+5
        ta[4] = '{7, -1, 0, 3, 2, 5};   tbv[4] = '{7, 2, 9, 3, -4, 1};
        e0[4] = 41;  e1[4] = 12;

        a = '0; b = '0; v = 1'b0; cr = 1'b1;
        wa = '0; wb = '0; wv = 1'b0; w_cr = 1'b1;
        ok = 1'b0;

        // Reset state
        repeat (2) step();
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_c_valid",  64'(c_valid),  64'd0);
        chk("rst_c_last",   64'(c_last),   64'd0);
        chk("rst_c_index",  64'(c_index),  64'd0);
        chk("rst_c_data",   c_data,        64'd0);
        chk("rst_ovf",      64'(ovf),      64'd0);
        chk("rst_w_valid",  64'(w_valid),  64'd0);
        rst_n = 1'b1;
        step();

        // Single tile: result visible two edges after the final beat.
        ir_low = 0;
        send(0, 0, 6);
        chk("t1_lat0", 64'(c_valid), 64'd0);
        step();
        chk("t1_lat1", 64'(c_valid), 64'd0);
        step();
        chk("t1_valid0", 64'(c_valid), 64'd1);
        chk("t1_data0",  c_data,       64'd22);
        chk("t1_idx0",   64'(c_index), 64'd0);
        chk("t1_last0",  64'(c_last),  64'd0);
        step();
        chk("t1_valid1", 64'(c_valid), 64'd1);
        chk("t1_data1",  c_data,       64'd72);
        chk("t1_idx1",   64'(c_index), 64'd1);
        chk("t1_last1",  64'(c_last),  64'd1);
        step();
        chk("t1_valid2", 64'(c_valid), 64'd0);
        chk("t1_ir",     64'(ir_low),  64'd0);
        check_q("t1_q", 0, 1);
        qclear();

        // Back-to-back tiles with no gap
        ir_low = 0;
        send(1, 0, 6);
        send(2, 0, 6);
        repeat (4) step();
        chk("b2b_ir",  64'(ir_low), 64'd0);
        chk("b2b_ovf", 64'(ovf),    64'd0);
        check_q("b2b_q", 1, 2);
        qclear();

        // Drain stall: only the second tile's final beat is held off.
        cr = 1'b0;
        ir_low = 0;
        send(3, 0, 6);
        send(4, 0, 5);
        chk("stall_ir_nonfinal", 64'(ir_low), 64'd0);
        a = 64'(ta[4][5]);
        b = 64'(tbv[4][5]);
        v = 1'b1;
        #1;
        chk("stall_ir_final", 64'(in_ready), 64'd0);
        step();
        v = 1'b0;
        chk("ovf_set",    64'(ovf),     64'd1);
        chk("stall_val",  64'(c_valid), 64'd1);
        chk("stall_data", c_data,       64'd23);
        repeat (3) step();
        chk("hold_data",  c_data,       64'd23);
        chk("hold_idx",   64'(c_index), 64'd0);
        chk("hold_last",  64'(c_last),  64'd0);
        chk("hold_valid", 64'(c_valid), 64'd1);
        chk("ovf_sticky", 64'(ovf),     64'd1);

        // Release the drain, then re-offer the dropped final beat.
        cr = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            #1;
            if (in_ready) begin
                a = 64'(ta[4][5]);
                b = 64'(tbv[4][5]);
                v = 1'b1;
                ok = 1'b1;
            end
            step();
            v = 1'b0;
        end
        chk("stall_accept", 64'(ok), 64'd1);
        repeat (5) step();
        check_q("stall_q", 3, 2);
        chk("ovf_sticky2", 64'(ovf), 64'd1);
        qclear();

        // Reset mid-tile
        send(1, 0, 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rt_in_ready", 64'(in_ready), 64'd1);
        chk("rt_c_valid",  64'(c_valid),  64'd0);
        chk("rt_ovf",      64'(ovf),      64'd0);
        chk("rt_c_data",   c_data,        64'd0);
        chk("rt_c_index",  64'(c_index),  64'd0);
        chk("rt_c_last",   64'(c_last),   64'd0);
        step();
        rst_n = 1'b1;
        step();
        qclear();
        send(1, 0, 6);
        repeat (4) step();
        check_q("rt_q", 1, 1);
        qclear();

        // Reset mid-drain, after one row has already been taken.
        cr = 1'b0;
        send(2, 0, 6);
        repeat (2) step();
        chk("rd_pre_valid", 64'(c_valid), 64'd1);
        cr = 1'b1;
        step();
        cr = 1'b0;
        chk("rd_pre_idx", 64'(c_index), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rd_c_valid", 64'(c_valid), 64'd0);
        chk("rd_c_data",  c_data,       64'd0);
        chk("rd_c_index", 64'(c_index), 64'd0);
        chk("rd_c_last",  64'(c_last),  64'd0);
        step();
        rst_n = 1'b1;
        cr = 1'b1;
        step();
        qclear();
        send(4, 0, 6);
        repeat (4) step();
        check_q("rd_q", 4, 1);
        qclear();

        // 8-bit wrap: row0 127*1 + 1*1 = 0x80, row1 2*3 + 4*5 = 0x1A
        wa = 8'd127; wb = 8'd1; wv = 1'b1; step();
        wa = 8'd2;   wb = 8'd3;            step();
        wa = 8'd1;   wb = 8'd1;            step();
        wa = 8'd4;   wb = 8'd5;            step();
        wv = 1'b0;
        step();
        step();
        chk("wrap_valid0", 64'(w_valid), 64'd1);
        chk("wrap_data0",  64'(w_data),  64'h80);
        chk("wrap_idx0",   64'(w_index), 64'd0);
        step();
        chk("wrap_data1",  64'(w_data),  64'h1A);
        chk("wrap_last1",  64'(w_last),  64'd1);
        step();
        chk("wrap_valid2", 64'(w_valid), 64'd0);
        chk("wrap_ovf",    64'(w_ovf),   64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
